// File: rtl/telem_frame_rx_if.sv
// Byte link from the telemetry source into the frame receiver.
// A byte transfers on any rising edge where rx_valid and rx_ready are both high.
interface telem_frame_rx_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;

   modport master (output rx_data, output rx_valid, input rx_ready);
   modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/telem_frame_rx.sv
// Telemetry frame receiver.
// Hunts for the sync byte and assembles SYNC,HDR,X,Y,Z,T,CSUM.
// A frame with a good checksum produces a one-cycle write of target id and
// coordinates. Frames with a bad header, a bad checksum or a stall are dropped
// and counted in a saturating error counter.
module telem_frame_rx #(
   parameter logic [7:0]  SYNC_BYTE = 8'hA5,
   parameter int unsigned TIMEOUT   = 16,
   parameter int unsigned ERR_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   telem_frame_rx_if.slave  i_rx,
   output logic             o_wr_en,
   output logic [3:0]       o_target_sel,
   output logic [7:0]       o_x_coord,
   output logic [7:0]       o_y_coord,
   output logic [7:0]       o_z_coord,
   output logic [7:0]       o_t_coord,
   output logic             o_busy,
   output logic [ERR_W-1:0] o_err_cnt
);

   localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_HUNT, S_HDR, S_BX, S_BY, S_BZ, S_BT, S_CSUM, S_COMMIT
   } state_t;

   state_t            r_state;
   logic              r_rx_ready;
   logic              r_wr_en;
   logic              r_busy;
   logic [ERR_W-1:0]  r_err_cnt;
   logic [IDLE_W-1:0] r_idle;
   logic [3:0]        r_sh_tgt;
   logic [7:0]        r_sh_x, r_sh_y, r_sh_z, r_sh_t;
   logic [3:0]        r_target_sel;
   logic [7:0]        r_x_coord, r_y_coord, r_z_coord, r_t_coord;

   logic              w_acc;
   logic              w_in_frame;
   logic              w_timeout;
   logic              w_bad_hdr;
   logic              w_bad_csum;
   logic              w_drop;
   logic [7:0]        w_csum_calc;

   assign w_acc       = i_rx.rx_valid & r_rx_ready;
   assign w_in_frame  = (r_state != S_HUNT) && (r_state != S_COMMIT);
   assign w_timeout   = w_in_frame && !w_acc && (r_idle == IDLE_W'(TIMEOUT - 1));
   assign w_bad_hdr   = (r_state == S_HDR) && w_acc && (i_rx.rx_data[7:4] != 4'h0);
   assign w_csum_calc = {4'h0, r_sh_tgt} ^ r_sh_x ^ r_sh_y ^ r_sh_z ^ r_sh_t;
   assign w_bad_csum  = (r_state == S_CSUM) && w_acc && (i_rx.rx_data != w_csum_calc);
   // The three drop causes are mutually exclusive in a cycle, so the count
   // never moves by more than one.
   assign w_drop      = w_timeout | w_bad_hdr | w_bad_csum;

   // Frame FSM with idle timer, shadow capture, commit and error counting
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_HUNT;
         r_rx_ready   <= 1'b1;
         r_wr_en      <= 1'b0;
         r_busy       <= 1'b0;
         r_err_cnt    <= '0;
         r_idle       <= '0;
         r_sh_tgt     <= '0;
         r_sh_x       <= '0;
         r_sh_y       <= '0;
         r_sh_z       <= '0;
         r_sh_t       <= '0;
         r_target_sel <= '0;
         r_x_coord    <= '0;
         r_y_coord    <= '0;
         r_z_coord    <= '0;
         r_t_coord    <= '0;
      end else begin
         r_wr_en    <= 1'b0;
         r_rx_ready <= 1'b1;

         if (w_drop && !(&r_err_cnt))
            r_err_cnt <= r_err_cnt + 1'b1;

         if (w_in_frame && !w_acc && !w_timeout)
            r_idle <= r_idle + 1'b1;
         else
            r_idle <= '0;

         case (r_state)
            S_HUNT: begin
               if (w_acc && (i_rx.rx_data == SYNC_BYTE)) begin
                  r_state <= S_HDR;
                  r_busy  <= 1'b1;
               end
            end
            S_HDR: begin
               if (w_acc) begin
                  if (w_bad_hdr) begin
                     r_state <= S_HUNT;
                     r_busy  <= 1'b0;
                  end else begin
                     r_sh_tgt <= i_rx.rx_data[3:0];
                     r_state  <= S_BX;
                  end
               end
            end
            S_BX: if (w_acc) begin r_sh_x <= i_rx.rx_data; r_state <= S_BY; end
            S_BY: if (w_acc) begin r_sh_y <= i_rx.rx_data; r_state <= S_BZ; end
            S_BZ: if (w_acc) begin r_sh_z <= i_rx.rx_data; r_state <= S_BT; end
            S_BT: if (w_acc) begin r_sh_t <= i_rx.rx_data; r_state <= S_CSUM; end
            S_CSUM: begin
               if (w_acc) begin
                  if (w_bad_csum) begin
                     r_state <= S_HUNT;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state      <= S_COMMIT;
                     r_wr_en      <= 1'b1;
                     r_rx_ready   <= 1'b0;
                     r_target_sel <= r_sh_tgt;
                     r_x_coord    <= r_sh_x;
                     r_y_coord    <= r_sh_y;
                     r_z_coord    <= r_sh_z;
                     r_t_coord    <= r_sh_t;
                  end
               end
            end
            S_COMMIT: begin
               r_state <= S_HUNT;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_HUNT;
               r_busy  <= 1'b0;
            end
         endcase

         // Timeout only fires without an accepted byte, so it never collides
         // with a case-branch transition above.
         if (w_timeout) begin
            r_state <= S_HUNT;
            r_busy  <= 1'b0;
         end
      end
   end

   assign i_rx.rx_ready = r_rx_ready;
   assign o_wr_en       = r_wr_en;
   assign o_target_sel  = r_target_sel;
   assign o_x_coord     = r_x_coord;
   assign o_y_coord     = r_y_coord;
   assign o_z_coord     = r_z_coord;
   assign o_t_coord     = r_t_coord;
   assign o_busy        = r_busy;
   assign o_err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_telem_frame_rx.sv
// Scoreboard bench for telem_frame_rx: expected writes are queued as frames
// are driven and matched against each wr_en pulse, including its cycle.
module tb_telem_frame_rx;

   localparam int unsigned TIMEOUT = 16;
   localparam int unsigned ERR_W   = 4;
   localparam logic [ERR_W-1:0] ERR_MAX = '1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             wr_en;
   logic [3:0]       target_sel;
   logic [7:0]       x_coord, y_coord, z_coord, t_coord;
   logic             busy;
   logic [ERR_W-1:0] err_cnt;

   telem_frame_rx_if u_if ();

   telem_frame_rx #(
      .SYNC_BYTE (8'hA5),
      .TIMEOUT   (TIMEOUT),
      .ERR_W     (ERR_W)
   ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .i_rx         (u_if),
      .o_wr_en      (wr_en),
      .o_target_sel (target_sel),
      .o_x_coord    (x_coord),
      .o_y_coord    (y_coord),
      .o_z_coord    (z_coord),
      .o_t_coord    (t_coord),
      .o_busy       (busy),
      .o_err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  tgt;
      logic [7:0]  x, y, z, t;
      int unsigned cyc;
   } wr_t;

   wr_t         exp_q[$];
   int unsigned cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   bit          mon_en = 1'b0;

   // Reference model: last committed values and error count
   logic [3:0]       m_tgt = '0;
   logic [7:0]       m_x = '0, m_y = '0, m_z = '0, m_t = '0;
   logic [ERR_W-1:0] m_err = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic err_event();
      if (m_err != ERR_MAX) m_err = m_err + 1'b1;
   endtask

   // Called at posedge+1; returns at posedge+1 after the byte was taken
   task automatic send_byte(input logic [7:0] b);
      int w;
      u_if.rx_data  = b;
      u_if.rx_valid = 1'b1;
      w = 0;
      while (!u_if.rx_ready && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      if (w >= 20) check("rdy_stuck", 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      u_if.rx_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send_frame(input logic [7:0] hdr, input logic [7:0] x, input logic [7:0] y,
                             input logic [7:0] z, input logic [7:0] t, input bit corrupt,
                             input int gap_after_x);
      logic [7:0] cs;
      wr_t e;
      cs = hdr ^ x ^ y ^ z ^ t;
      if (corrupt) cs = cs ^ 8'h07;
      send_byte(8'hA5);
      send_byte(hdr);
      send_byte(x);
      if (gap_after_x > 0) idle(gap_after_x);
      send_byte(y);
      send_byte(z);
      send_byte(t);
      send_byte(cs);
      if (corrupt) begin
         err_event();
      end else begin
         e.tgt = hdr[3:0]; e.x = x; e.y = y; e.z = z; e.t = t; e.cyc = cyc;
         exp_q.push_back(e);
         m_tgt = hdr[3:0]; m_x = x; m_y = y; m_z = z; m_t = t;
      end
   endtask

   task automatic check_outs(input string tag);
      check({tag, "_tgt"}, target_sel, m_tgt);
      check({tag, "_x"}, x_coord, m_x);
      check({tag, "_y"}, y_coord, m_y);
      check({tag, "_z"}, z_coord, m_z);
      check({tag, "_t"}, t_coord, m_t);
      check({tag, "_err"}, err_cnt, m_err);
   endtask

   // Output monitor: every wr_en pulse must match the head of the queue
   always @(negedge clk) begin
      wr_t e;
      if (mon_en && !rst) begin
         if (wr_en) begin
            check("rdy_commit", u_if.rx_ready, 0);
            if (exp_q.size() == 0) begin
               check("wr_unexp", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("wr_tgt", target_sel, e.tgt);
               check("wr_x", x_coord, e.x);
               check("wr_y", y_coord, e.y);
               check("wr_z", z_coord, e.z);
               check("wr_t", t_coord, e.t);
               check("wr_lat", cyc, e.cyc);
            end
         end else begin
            check("rdy_idle", u_if.rx_ready, 1);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      u_if.rx_valid = 1'b0;
      u_if.rx_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      mon_en = 1'b1;
      check("rst_wr", wr_en, 0);
      check("rst_busy", busy, 0);
      check("rst_rdy", u_if.rx_ready, 1);
      check_outs("rst");

      // Basic good frame
      send_frame(8'h03, 8'h10, 8'h20, 8'h30, 8'h40, 1'b0, 0);
      idle(2);
      check_outs("good");

      // Bad checksum: no write, outputs hold
      send_frame(8'h03, 8'h10, 8'h20, 8'h30, 8'h40, 1'b1, 0);
      idle(2);
      check("bad_busy", busy, 0);
      check_outs("badcs");

      // Garbage in HUNT, then target F
      send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
      send_frame(8'h0F, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 0);
      idle(2);
      check_outs("garb");

      // Stall inside frame: one cycle short of timeout keeps frame, full timeout drops
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'hAA);
      check("to_busy0", busy, 1);
      idle(TIMEOUT - 1);
      check("to_busy1", busy, 1);
      check("to_err1", err_cnt, m_err);
      idle(1);
      err_event();
      check("to_busy2", busy, 0);
      check_outs("tmo");
      send_frame(8'h01, 8'h55, 8'h66, 8'h77, 8'h88, 1'b0, 0);
      idle(2);
      check_outs("after_to");

      // Gap of TIMEOUT-1 inside a frame is tolerated
      send_frame(8'h07, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0, TIMEOUT - 1);
      idle(2);
      check_outs("gap");

      // Bad header 0x25
      send_byte(8'hA5); send_byte(8'h25);
      err_event();
      idle(2);
      check_outs("hdr25");

      // Bad header equal to SYNC is consumed; following bytes are not a frame
      send_byte(8'hA5); send_byte(8'hA5);
      err_event();
      send_byte(8'h03); send_byte(8'h10); send_byte(8'h20);
      send_byte(8'h30); send_byte(8'h40); send_byte(8'h43);
      idle(2);
      check_outs("hdrA5");

      // SYNC value as payload
      send_frame(8'h02, 8'hA5, 8'h5A, 8'hA5, 8'h00, 1'b0, 0);
      idle(2);
      check_outs("xa5");

      // Back-to-back frames with rx_valid held high
      send_frame(8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 0);
      send_frame(8'h05, 8'hF1, 8'hF2, 8'hF3, 8'hF4, 1'b0, 0);
      idle(3);
      check_outs("b2b");
      check("b2b_q", exp_q.size(), 0);

      // Error counter saturation
      for (int i = 0; i < 20; i++) begin
         send_byte(8'hA5); send_byte(8'h30);
         err_event();
      end
      idle(2);
      check("sat_model", m_err, ERR_MAX);
      check_outs("sat");

      // Reset during BY
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
      u_if.rx_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      m_tgt = '0; m_x = '0; m_y = '0; m_z = '0; m_t = '0; m_err = '0;
      check("rst2_busy", busy, 0);
      check("rst2_rdy", u_if.rx_ready, 1);
      check_outs("rst2");
      idle(3);
      check("rst2_wr", wr_en, 0);

      // Normal operation after reset
      send_frame(8'h09, 8'h99, 8'h88, 8'h77, 8'h66, 1'b0, 0);
      idle(3);
      check_outs("final");
      check("final_q", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
